// File: rtl/neopixel_pkg.sv
// Shared constants, FSM encoding and the ns-to-cycles helper for the WS2812 driver.
package neopixel_pkg;

    localparam logic [7:0] NP_ADDR_CTRL  = 8'hFE;
    localparam int         NP_CTRL_START = 0;
    localparam int         NP_CTRL_AUTO  = 1;
    localparam int         NP_WORD_W     = 24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SNAP  = 3'd1,
        BITH  = 3'd2,
        BITL  = 3'd3,
        LATCH = 3'd4
    } np_state_e;

    // Truncating conversion: floor(rate_hz * ns / 1e9).
    function automatic int ns_to_cycles(input longint rate_hz, input longint ns);
        return int'((rate_hz * ns) / 64'sd1000000000);
    endfunction

endpackage

// File: rtl/neopixel_bit_serializer.sv
// Shapes one 24-bit GRB word into WS2812 bit cells, MSB first, with back-to-back reload.
module neopixel_bit_serializer
    import neopixel_pkg::*;
#(
    parameter int T0H_CYC = 50,
    parameter int T1H_CYC = 100,
    parameter int BIT_CYC = 156
) (
    input  logic                 ctrl_clock,
    input  logic                 ctrl_reset_n,
    input  logic                 load,
    input  logic [NP_WORD_W-1:0] word,
    output logic                 dout,
    output logic                 high_end,
    output logic                 bit_end,
    output logic                 word_done
);

    localparam int            TW       = $clog2(BIT_CYC);
    localparam logic [TW-1:0] T0H_LAST = TW'(T0H_CYC - 1);
    localparam logic [TW-1:0] T1H_LAST = TW'(T1H_CYC - 1);
    localparam logic [TW-1:0] BIT_LAST = TW'(BIT_CYC - 1);

    logic [TW-1:0] bit_timer;
    logic [4:0]    bit_idx;
    logic          running;
    logic [TW-1:0] high_last;

    // The word is read live; the caller keeps it stable for the whole word.
    assign high_last = word[bit_idx] ? T1H_LAST : T0H_LAST;
    assign high_end  = running && (bit_timer == high_last);
    assign bit_end   = running && (bit_timer == BIT_LAST);
    assign word_done = bit_end && (bit_idx == 5'd0);

    always_ff @(posedge ctrl_clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            running   <= 1'b0;
            bit_timer <= '0;
            bit_idx   <= '0;
            dout      <= 1'b0;
        end else if (load) begin
            running   <= 1'b1;
            bit_timer <= '0;
            bit_idx   <= 5'(NP_WORD_W - 1);
            dout      <= 1'b1;
        end else if (running) begin
            if (bit_end) begin
                bit_timer <= '0;
                if (bit_idx == 5'd0) begin
                    running <= 1'b0;
                    dout    <= 1'b0;
                end else begin
                    bit_idx <= bit_idx - 5'd1;
                    dout    <= 1'b1;
                end
            end else begin
                bit_timer <= bit_timer + 1'b1;
                if (high_end) begin
                    dout <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/neopixel_driver.sv
// WS2812 frame driver: shadow/active pixel banks, CTRL register, frame FSM and status readback.
module neopixel_driver
    import neopixel_pkg::*;
#(
    parameter int C_RATE     = 125000000,
    parameter int C_PIXELS   = 12,
    parameter int C_T0H_NS   = 400,
    parameter int C_T1H_NS   = 800,
    parameter int C_BIT_NS   = 1250,
    parameter int C_LATCH_NS = 80000
) (
    input  logic        ctrl_clock,
    input  logic        ctrl_reset_n,
    input  logic        ctrl_write_en,
    input  logic [31:0] ctrl_address,
    input  logic [31:0] ctrl_write_data,
    output logic [31:0] ctrl_read_data,
    output logic        ctrl_ready,
    output logic        neopixel_dout
);

    localparam int T0H_CYC   = ns_to_cycles(C_RATE, C_T0H_NS);
    localparam int T1H_CYC   = ns_to_cycles(C_RATE, C_T1H_NS);
    localparam int BIT_CYC   = ns_to_cycles(C_RATE, C_BIT_NS);
    localparam int LATCH_CYC = ns_to_cycles(C_RATE, C_LATCH_NS);
    localparam int PIX_W     = (C_PIXELS > 1) ? $clog2(C_PIXELS) : 1;
    localparam int LAT_W     = $clog2(LATCH_CYC + 1);

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(C_PIXELS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYC - 1);
    localparam logic [8:0]       NPIX     = 9'(C_PIXELS);

    logic [NP_WORD_W-1:0] shadow_q [C_PIXELS];
    logic [NP_WORD_W-1:0] shadow_d [C_PIXELS];
    logic [NP_WORD_W-1:0] active_q [C_PIXELS];

    np_state_e        state;
    logic [PIX_W-1:0] pix;
    logic [LAT_W-1:0] latch_timer;
    logic             pending;
    logic             auto_en;
    logic [15:0]      frame_count;

    logic [7:0] addr8;
    logic       ctrl_hit;
    logic       pix_write;
    logic       ser_load;
    logic       ser_high_end;
    logic       ser_bit_end;
    logic       ser_word_done;
    logic       unused_bits;

    assign addr8       = ctrl_address[7:0];
    assign ctrl_hit    = ctrl_write_en && (addr8 == NP_ADDR_CTRL);
    // CTRL wins if a 255-pixel build makes 8'hFE also a pixel address.
    assign pix_write   = ctrl_write_en && !ctrl_hit && ({1'b0, addr8} < NPIX);
    assign unused_bits = ^{ctrl_address[31:8], ctrl_write_data[31:24]};

    always_comb begin
        for (int i = 0; i < C_PIXELS; i++) begin
            shadow_d[i] = shadow_q[i];
            if (pix_write && (addr8 == 8'(i))) begin
                shadow_d[i] = ctrl_write_data[NP_WORD_W-1:0];
            end
        end
    end

    // Snapshot from shadow_d so a write landing in the SNAP cycle makes this frame.
    always_ff @(posedge ctrl_clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < C_PIXELS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < C_PIXELS; i++) begin
                shadow_q[i] <= shadow_d[i];
                if (state == SNAP) begin
                    active_q[i] <= shadow_d[i];
                end
            end
        end
    end

    assign ser_load = (state == SNAP) ||
                      ((state == BITL) && ser_word_done && (pix != PIX_LAST));

    neopixel_bit_serializer #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC)
    ) u_serializer (
        .ctrl_clock   (ctrl_clock),
        .ctrl_reset_n (ctrl_reset_n),
        .load         (ser_load),
        .word         (active_q[pix]),
        .dout         (neopixel_dout),
        .high_end     (ser_high_end),
        .bit_end      (ser_bit_end),
        .word_done    (ser_word_done)
    );

    always_ff @(posedge ctrl_clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state       <= IDLE;
            pix         <= '0;
            latch_timer <= '0;
            pending     <= 1'b0;
            auto_en     <= 1'b0;
            frame_count <= '0;
        end else begin
            if (ctrl_hit) begin
                auto_en <= ctrl_write_data[NP_CTRL_AUTO];
            end
            // A start arriving in the SNAP cycle survives for the following frame.
            if (ctrl_hit && ctrl_write_data[NP_CTRL_START]) begin
                pending <= 1'b1;
            end else if (state == SNAP) begin
                pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pending || auto_en) begin
                        state <= SNAP;
                    end
                end
                SNAP: begin
                    pix   <= '0;
                    state <= BITH;
                end
                BITH: begin
                    if (ser_high_end) begin
                        state <= BITL;
                    end
                end
                BITL: begin
                    if (ser_bit_end) begin
                        if (ser_word_done && (pix == PIX_LAST)) begin
                            latch_timer <= '0;
                            state       <= LATCH;
                        end else begin
                            if (ser_word_done) begin
                                pix <= pix + 1'b1;
                            end
                            state <= BITH;
                        end
                    end
                end
                LATCH: begin
                    if (latch_timer == LAT_LAST) begin
                        frame_count <= frame_count + 16'd1;
                        state       <= (pending || auto_en) ? SNAP : IDLE;
                    end else begin
                        latch_timer <= latch_timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ctrl_clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            ctrl_read_data <= '0;
            ctrl_ready     <= 1'b0;
        end else begin
            ctrl_read_data <= {(state != IDLE), pending, auto_en, 13'd0, frame_count};
            ctrl_ready     <= (state == IDLE) && !pending;
        end
    end

endmodule

// File: tb/tb_neopixel_driver.sv
// Bench for neopixel_driver: random pixel words checked against a frame model built from WS2812 timing rules.
module tb_neopixel_driver;

    localparam longint RATE     = 25000000;
    localparam int     PIX      = 5;
    localparam longint T0H_NS   = 400;
    localparam longint T1H_NS   = 800;
    localparam longint BIT_NS   = 1250;
    localparam longint LATCH_NS = 8000;

    localparam int T0H    = int'(RATE * T0H_NS / 1000000000);
    localparam int T1H    = int'(RATE * T1H_NS / 1000000000);
    localparam int BITC   = int'(RATE * BIT_NS / 1000000000);
    localparam int LATCHC = int'(RATE * LATCH_NS / 1000000000);

    localparam logic [31:0] CTRL_ADDR  = 32'h0000_00FE;
    localparam int          RISE_LIMIT = 50;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        dout;

    int          checks;
    int          errors;
    int          frames_exp;
    int          rw;
    logic [23:0] model [PIX];
    logic [23:0] exp_a [PIX];
    logic [23:0] exp_b [PIX];

    neopixel_driver #(
        .C_RATE     (int'(RATE)),
        .C_PIXELS   (PIX),
        .C_T0H_NS   (int'(T0H_NS)),
        .C_T1H_NS   (int'(T1H_NS)),
        .C_BIT_NS   (int'(BIT_NS)),
        .C_LATCH_NS (int'(LATCH_NS))
    ) dut (
        .ctrl_clock      (clk),
        .ctrl_reset_n    (rst_n),
        .ctrl_write_en   (we),
        .ctrl_address    (addr),
        .ctrl_write_data (wdata),
        .ctrl_read_data  (rdata),
        .ctrl_ready      (ready),
        .neopixel_dout   (dout)
    );

    always #4 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called on a falling edge; the write is sampled by the next rising edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        if (a[7:0] != 8'hFE && int'(a[7:0]) < PIX) begin
            model[a[7:0]] = d[23:0];
        end
        @(negedge clk);
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic receiveFrame(input logic [23:0] exp_words [PIX], input string tag, output int rise_wait);
        logic [23:0] got [PIX];
        int hi;
        int lo;
        int tail;
        int bad;
        int last_hi;
        rise_wait = 0;
        while (dout !== 1'b1 && rise_wait < RISE_LIMIT) begin
            @(negedge clk);
            rise_wait++;
        end
        checkOutput($sformatf("%s_start", tag), 32'(dout), 32'd1);
        if (dout !== 1'b1) return;
        bad = 0;
        for (int p = 0; p < PIX; p++) begin
            for (int b = 23; b >= 0; b--) begin
                hi = 0;
                while (dout === 1'b1 && hi < 2 * BITC) begin
                    @(negedge clk);
                    hi++;
                end
                got[p][b] = (hi > (T0H + T1H) / 2);
                if (hi != T0H && hi != T1H) bad++;
                if (p != PIX - 1 || b != 0) begin
                    lo = 0;
                    while (dout === 1'b0 && lo < 2 * BITC) begin
                        @(negedge clk);
                        lo++;
                    end
                    if (hi + lo != BITC) bad++;
                end
            end
        end
        tail = 0;
        while (dout === 1'b0 && rdata[31] === 1'b1 && tail < BITC + LATCHC + 50) begin
            @(negedge clk);
            tail++;
        end
        last_hi = exp_words[PIX-1][0] ? T1H : T0H;
        for (int p = 0; p < PIX; p++) begin
            checkOutput($sformatf("%s_pix%0d", tag, p), {8'd0, got[p]}, {8'd0, exp_words[p]});
        end
        checkOutput($sformatf("%s_pulse_timing", tag), 32'(bad), 32'd0);
        checkOutput($sformatf("%s_latch_low", tag), 32'(tail), 32'(BITC - last_hi + LATCHC + 1));
        frames_exp++;
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clk = 1'b0; rst_n = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        checks = 0; errors = 0; frames_exp = 0; rw = 0;
        for (int i = 0; i < PIX; i++) model[i] = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_dout", 32'(dout), 32'd0);
        checkOutput("reset_read_data", rdata, 32'd0);
        checkOutput("reset_ready", 32'(ready), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_ready", 32'(ready), 32'd1);
        checkOutput("idle_read_data", rdata, 32'd0);

        $display("[TB] first frame, pix0 = 800001, start latency");
        applyStimulus(32'd0, 32'h0080_0001);
        for (int i = 1; i < PIX; i++) applyStimulus(32'(i), $urandom());
        exp_a = model;
        applyStimulus(CTRL_ADDR, 32'd1);
        receiveFrame(exp_a, "frame1", rw);
        checkOutput("start_latency", 32'(rw), 32'd2);
        checkOutput("frame1_status", rdata, {16'd0, 16'(frames_exp)});
        checkOutput("frame1_ready", 32'(ready), 32'd1);

        $display("[TB] mid-frame pixel write does not tear");
        applyStimulus(32'd3, $urandom() & 32'h007F_FFFF);
        exp_a = model;
        applyStimulus(CTRL_ADDR, 32'd1);
        fork
            receiveFrame(exp_a, "frame2", rw);
            begin
                repeat (400) @(negedge clk);
                applyStimulus(32'd3, 32'h00FF_FFFF);
            end
        join
        checkOutput("frame2_count", {16'd0, rdata[15:0]}, 32'(frames_exp));
        exp_b = model;
        applyStimulus(CTRL_ADDR, 32'd1);
        receiveFrame(exp_b, "frame3", rw);

        $display("[TB] start held pending while a frame is in flight");
        exp_a = model;
        applyStimulus(CTRL_ADDR, 32'd1);
        fork
            receiveFrame(exp_a, "frame4", rw);
            begin
                repeat (300) @(negedge clk);
                for (int k = 0; k < BITC && dout !== 1'b0; k++) @(negedge clk);
                applyStimulus(CTRL_ADDR, 32'd1);
                @(negedge clk);
                checkOutput("pending_flag", 32'(rdata[30]), 32'd1);
                checkOutput("pending_ready", 32'(ready), 32'd0);
                applyStimulus(32'd2, $urandom());
            end
        join
        exp_b = model;
        receiveFrame(exp_b, "frame5", rw);
        checkOutput("pending_back_to_back", 32'(rw), 32'd0);
        checkOutput("frame5_status", rdata, {16'd0, 16'(frames_exp)});
        checkOutput("frame5_ready", 32'(ready), 32'd1);

        $display("[TB] auto-refresh");
        for (int i = 0; i < PIX; i++) applyStimulus(32'(i), $urandom());
        applyStimulus(CTRL_ADDR, 32'd2);
        exp_a = model;
        receiveFrame(exp_a, "auto1", rw);
        checkOutput("auto_latency", 32'(rw), 32'd2);
        fork
            receiveFrame(exp_a, "auto2", rw);
            begin
                repeat (200) @(negedge clk);
                applyStimulus(CTRL_ADDR, 32'd0);
            end
        join
        checkOutput("auto_back_to_back", 32'(rw), 32'd0);
        checkOutput("auto_stop_status", rdata, {16'd0, 16'(frames_exp)});
        repeat (40) @(negedge clk);
        checkOutput("auto_stays_idle", {30'd0, dout, rdata[31]}, 32'd0);

        $display("[TB] ignored addresses");
        applyStimulus(32'(PIX), $urandom());
        applyStimulus(32'h0000_00FD, 32'hFFFF_FFFF);
        applyStimulus(32'h0000_00FF, 32'hFFFF_FFFF);
        applyStimulus(32'h1234_5601, $urandom());
        repeat (5) @(negedge clk);
        checkOutput("ignored_no_start", {27'd0, ready, dout, rdata[31:29]}, 32'h10);
        exp_a = model;
        applyStimulus(CTRL_ADDR, 32'd1);
        receiveFrame(exp_a, "frame_ignored", rw);

        $display("[TB] reset mid-frame");
        applyStimulus(CTRL_ADDR, 32'd1);
        repeat (600) @(negedge clk);
        for (int k = 0; k < BITC && dout !== 1'b1; k++) @(negedge clk);
        checkOutput("pre_reset_high", 32'(dout), 32'd1);
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_async_dout", 32'(dout), 32'd0);
        @(negedge clk);
        checkOutput("reset_mid_status", {31'd0, ready} | rdata, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < PIX; i++) model[i] = '0;
        frames_exp = 0;
        @(negedge clk);
        exp_a = model;
        applyStimulus(CTRL_ADDR, 32'd1);
        receiveFrame(exp_a, "after_reset", rw);
        checkOutput("after_reset_count", rdata, {16'd0, 16'(frames_exp)});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
